// File: rtl/i2c_slave_reg_bank.sv
// Register bank behind the I2C slave: write-edge commit, registered reads,
// debounced switches/buttons with sticky press flags and IRQ, 32-byte LCD buffer.
module i2c_slave_reg_bank #(
    parameter int NUM_SW         = 8,
    parameter int NUM_BTN        = 4,
    parameter int DEB_CYCLES     = 50000,
    parameter int WR_ADDR_OFFSET = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         RAM_Addr,
    input  logic [7:0]         RemoteRAM_DIN,
    input  logic               RemoteRAM_W,
    output logic [7:0]         LocalRAM_DOUT,
    input  logic [NUM_SW-1:0]  sw_in,
    input  logic [NUM_BTN-1:0] btn_in,
    input  logic [4:0]         lcd_rd_addr,
    output logic [7:0]         lcd_rd_data,
    output logic               irq
);

    localparam int NIN = NUM_SW + NUM_BTN;
    localparam int CW  = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [7:0]    ADDR_OFS = 8'(WR_ADDR_OFFSET);

    localparam logic [7:0] A_ID   = 8'h00;
    localparam logic [7:0] A_SW   = 8'h01;
    localparam logic [7:0] A_BTN  = 8'h02;
    localparam logic [7:0] A_EVT  = 8'h03;
    localparam logic [7:0] A_IEN  = 8'h04;
    localparam logic [7:0] A_CTRL = 8'h05;

    // Switches occupy the low bits, buttons the high bits of each vector.
    logic [NIN-1:0]     sync1;
    logic [NIN-1:0]     sync2;
    logic [NIN-1:0]     deb;
    logic [CW-1:0]      cnt [NIN];
    logic [NUM_SW-1:0]  sw_deb;
    logic [NUM_BTN-1:0] btn_deb;
    logic [NUM_BTN-1:0] btn_rise;

    logic               w_q;
    logic               commit;
    logic [7:0]         waddr;
    logic [NUM_BTN-1:0] btn_clr;
    logic [NUM_BTN-1:0] btn_evt;
    logic [NUM_BTN-1:0] irq_en;
    logic [7:0]         ctrl;
    logic [7:0]         lcd [32];
    logic [7:0]         rd_data;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            for (int unsigned i = 0; i < NIN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= {btn_in, sw_in};
            sync2 <= sync1;
            for (int unsigned i = 0; i < NIN; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // A rising press is flagged in the same cycle the debounced bit flips.
    always_comb begin
        sw_deb   = deb[NUM_SW-1:0];
        btn_deb  = deb[NIN-1:NUM_SW];
        btn_rise = '0;
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            btn_rise[i] = sync2[NUM_SW+i] && !deb[NUM_SW+i] && (cnt[NUM_SW+i] == CNT_LAST);
        end
    end

    always_comb begin
        commit  = RemoteRAM_W && !w_q;
        waddr   = RAM_Addr - ADDR_OFS;
        btn_clr = '0;
        if (commit && (waddr == A_EVT)) begin
            btn_clr = RemoteRAM_DIN[NUM_BTN-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            w_q     <= 1'b1;
            btn_evt <= '0;
            irq_en  <= '0;
            ctrl    <= '0;
            for (int unsigned i = 0; i < 32; i++) begin
                lcd[i] <= 8'h20;
            end
        end else begin
            w_q     <= RemoteRAM_W;
            btn_evt <= (btn_evt & ~btn_clr) | btn_rise;
            if (commit) begin
                if (waddr == A_IEN) begin
                    irq_en <= RemoteRAM_DIN[NUM_BTN-1:0];
                end
                if (waddr == A_CTRL) begin
                    ctrl <= RemoteRAM_DIN;
                end
                if (waddr[7:5] == 3'b001) begin
                    lcd[waddr[4:0]] <= RemoteRAM_DIN;
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (RAM_Addr)
            A_ID:    rd_data = 8'hA5;
            A_SW:    rd_data[NUM_SW-1:0]  = sw_deb;
            A_BTN:   rd_data[NUM_BTN-1:0] = btn_deb;
            A_EVT:   rd_data[NUM_BTN-1:0] = btn_evt;
            A_IEN:   rd_data[NUM_BTN-1:0] = irq_en;
            A_CTRL:  rd_data = ctrl;
            default: begin
                if (RAM_Addr[7:5] == 3'b001) begin
                    rd_data = lcd[RAM_Addr[4:0]];
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            LocalRAM_DOUT <= '0;
            lcd_rd_data   <= '0;
            irq           <= 1'b0;
        end else begin
            LocalRAM_DOUT <= rd_data;
            lcd_rd_data   <= lcd[lcd_rd_addr];
            irq           <= |(btn_evt & irq_en);
        end
    end

endmodule

// File: tb/tb_i2c_slave_reg_bank.sv
// Self-checking bench for i2c_slave_reg_bank: random register traffic against a
// behavioural register-map model plus directed debounce, IRQ and reset scenarios.
module tb_i2c_slave_reg_bank;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] RAM_Addr;
    logic [7:0] RemoteRAM_DIN;
    logic       RemoteRAM_W;
    logic [7:0] LocalRAM_DOUT;
    logic [7:0] sw_in;
    logic [3:0] btn_in;
    logic [4:0] lcd_rd_addr;
    logic [7:0] lcd_rd_data;
    logic       irq;

    int total = 0;
    int bad   = 0;

    // Behavioural model of the register map
    logic [7:0] m_lcd [32];
    logic [7:0] m_ctrl;
    logic [3:0] m_en;
    logic [3:0] m_evt;
    logic [7:0] m_sw;
    logic [3:0] m_btn;

    i2c_slave_reg_bank #(
        .NUM_SW(8),
        .NUM_BTN(4),
        .DEB_CYCLES(4),
        .WR_ADDR_OFFSET(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .RAM_Addr(RAM_Addr),
        .RemoteRAM_DIN(RemoteRAM_DIN),
        .RemoteRAM_W(RemoteRAM_W),
        .LocalRAM_DOUT(LocalRAM_DOUT),
        .sw_in(sw_in),
        .btn_in(btn_in),
        .lcd_rd_addr(lcd_rd_addr),
        .lcd_rd_data(lcd_rd_data),
        .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, expected finish before timeout");
        $fatal(1);
    end

    function automatic logic [7:0] model_read(input logic [7:0] a);
        case (a)
            8'h00:   return 8'hA5;
            8'h01:   return m_sw;
            8'h02:   return {4'h0, m_btn};
            8'h03:   return {4'h0, m_evt};
            8'h04:   return {4'h0, m_en};
            8'h05:   return m_ctrl;
            default: return (a >= 8'h20 && a <= 8'h3F) ? m_lcd[a[4:0]] : 8'h00;
        endcase
    endfunction

    task automatic model_write(input logic [7:0] a, input logic [7:0] d);
        if (a == 8'h03) m_evt = m_evt & ~d[3:0];
        else if (a == 8'h04) m_en = d[3:0];
        else if (a == 8'h05) m_ctrl = d;
        else if (a >= 8'h20 && a <= 8'h3F) m_lcd[a[4:0]] = d;
    endtask

    task automatic model_reset();
        for (int unsigned i = 0; i < 32; i++) m_lcd[i] = 8'h20;
        m_ctrl = 8'h00;
        m_en   = 4'h0;
        m_evt  = 4'h0;
        m_btn  = 4'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One write transaction to target register a (slave address is one ahead)
    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        RAM_Addr      = a + 8'd1;
        RemoteRAM_DIN = d;
        RemoteRAM_W   = 1'b1;
        tick();
        RemoteRAM_W = 1'b0;
        tick();
        model_write(a, d);
    endtask

    task automatic test_reset();
        reset         = 1'b0;
        RAM_Addr      = 8'h00;
        RemoteRAM_DIN = 8'h00;
        RemoteRAM_W   = 1'b0;
        sw_in         = 8'h00;
        btn_in        = 4'h0;
        lcd_rd_addr   = 5'd0;
        m_sw          = 8'h00;
        model_reset();
        repeat (3) tick();
        total++;
        if (LocalRAM_DOUT !== 8'h00) begin
            bad++; $display("FAIL reset_dout: got %02h expected 00", LocalRAM_DOUT);
        end
        total++;
        if (lcd_rd_data !== 8'h00) begin
            bad++; $display("FAIL reset_lcd_data: got %02h expected 00", lcd_rd_data);
        end
        total++;
        if (irq !== 1'b0) begin
            bad++; $display("FAIL reset_irq: got %b expected 0", irq);
        end
        reset = 1'b1;
        for (int unsigned a = 0; a < 6; a++) begin
            RAM_Addr = 8'(a);
            tick();
            total++;
            if (LocalRAM_DOUT !== model_read(8'(a))) begin
                bad++; $display("FAIL reset_reg[%0d]: got %02h expected %02h", a, LocalRAM_DOUT, model_read(8'(a)));
            end
        end
        for (int unsigned k = 0; k < 4; k++) begin
            lcd_rd_addr = 5'($urandom_range(0, 31));
            tick();
            total++;
            if (lcd_rd_data !== 8'h20) begin
                bad++; $display("FAIL reset_lcd[%0d]: got %02h expected 20", lcd_rd_addr, lcd_rd_data);
            end
        end
    endtask

    task automatic test_write_once();
        RAM_Addr      = 8'h06;
        RemoteRAM_DIN = 8'h5A;
        RemoteRAM_W   = 1'b1;
        tick();
        RemoteRAM_DIN = 8'h11;
        repeat (9) tick();
        RemoteRAM_W = 1'b0;
        model_write(8'h05, 8'h5A);
        RAM_Addr = 8'h05;
        tick();
        total++;
        if (LocalRAM_DOUT !== 8'h5A) begin
            bad++; $display("FAIL write_once_ctrl: got %02h expected 5a", LocalRAM_DOUT);
        end
    endtask

    task automatic test_lcd();
        for (int unsigned i = 0; i < 32; i++) do_write(8'(8'h20 + i), 8'(8'h41 + i));
        lcd_rd_addr = 5'd31;
        tick();
        total++;
        if (lcd_rd_data !== 8'h60) begin
            bad++; $display("FAIL lcd_last: got %02h expected 60", lcd_rd_data);
        end
        do_write(8'h40, 8'h99);
        RAM_Addr = 8'h40;
        tick();
        total++;
        if (LocalRAM_DOUT !== 8'h00) begin
            bad++; $display("FAIL lcd_oob_read: got %02h expected 00", LocalRAM_DOUT);
        end
        for (int unsigned i = 0; i < 32; i++) begin
            lcd_rd_addr = 5'(i);
            tick();
            total++;
            if (lcd_rd_data !== m_lcd[i]) begin
                bad++; $display("FAIL lcd_port[%0d]: got %02h expected %02h", i, lcd_rd_data, m_lcd[i]);
            end
        end
        // Read and write of the same LCD byte in one cycle
        lcd_rd_addr   = 5'd5;
        RAM_Addr      = 8'h26;
        RemoteRAM_DIN = 8'hC3;
        RemoteRAM_W   = 1'b1;
        tick();
        total++;
        if (lcd_rd_data !== m_lcd[5]) begin
            bad++; $display("FAIL lcd_same_cycle_old: got %02h expected %02h", lcd_rd_data, m_lcd[5]);
        end
        RemoteRAM_W = 1'b0;
        model_write(8'h25, 8'hC3);
        tick();
        total++;
        if (lcd_rd_data !== 8'hC3) begin
            bad++; $display("FAIL lcd_same_cycle_new: got %02h expected c3", lcd_rd_data);
        end
    endtask

    task automatic test_random_regs();
        logic [7:0] a;
        logic [7:0] d;
        logic       exp_irq;
        repeat (40) begin
            a = 8'($urandom_range(0, 8'h45));
            d = 8'($urandom);
            do_write(a, d);
            exp_irq = |(m_evt & m_en);
            total++;
            if (irq !== exp_irq) begin
                bad++; $display("FAIL rand_irq: got %b expected %b", irq, exp_irq);
            end
        end
        repeat (40) begin
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 8'h3F));
            RAM_Addr = a;
            tick();
            total++;
            if (LocalRAM_DOUT !== model_read(a)) begin
                bad++; $display("FAIL rand_read[%02h]: got %02h expected %02h", a, LocalRAM_DOUT, model_read(a));
            end
        end
    endtask

    task automatic test_switches();
        repeat (4) begin
            m_sw  = 8'($urandom);
            sw_in = m_sw;
            repeat (8) tick();
            RAM_Addr = 8'h01;
            tick();
            total++;
            if (LocalRAM_DOUT !== m_sw) begin
                bad++; $display("FAIL sw_settle: got %02h expected %02h", LocalRAM_DOUT, m_sw);
            end
        end
        sw_in = ~m_sw;
        repeat (3) tick();
        sw_in = m_sw;
        repeat (8) tick();
        tick();
        total++;
        if (LocalRAM_DOUT !== m_sw) begin
            bad++; $display("FAIL sw_glitch: got %02h expected %02h", LocalRAM_DOUT, m_sw);
        end
    endtask

    task automatic test_debounce();
        logic [7:0] exp;
        btn_in = 4'b0001;
        repeat (3) tick();
        btn_in = 4'b0000;
        repeat (8) tick();
        RAM_Addr = 8'h02;
        tick();
        total++;
        if (LocalRAM_DOUT !== 8'h00) begin
            bad++; $display("FAIL btn_glitch: got %02h expected 00", LocalRAM_DOUT);
        end
        RAM_Addr = 8'h03;
        tick();
        total++;
        if (LocalRAM_DOUT !== {4'h0, m_evt}) begin
            bad++; $display("FAIL evt_glitch: got %02h expected %02h", LocalRAM_DOUT, {4'h0, m_evt});
        end
        // Debounced bit flips DEB_CYCLES+2 = 6 edges after the change; DOUT lags one more
        RAM_Addr = 8'h02;
        btn_in   = 4'b0001;
        for (int unsigned k = 1; k <= 10; k++) begin
            tick();
            exp = (k >= 7) ? 8'h01 : 8'h00;
            total++;
            if (LocalRAM_DOUT !== exp) begin
                bad++; $display("FAIL btn_latency[%0d]: got %02h expected %02h", k, LocalRAM_DOUT, exp);
            end
        end
        m_btn = 4'b0001;
        m_evt = m_evt | 4'b0001;
        RAM_Addr = 8'h03;
        tick();
        total++;
        if (LocalRAM_DOUT !== {4'h0, m_evt}) begin
            bad++; $display("FAIL evt_set: got %02h expected %02h", LocalRAM_DOUT, {4'h0, m_evt});
        end
        btn_in = 4'b0000;
        repeat (8) tick();
        m_btn = 4'b0000;
        RAM_Addr = 8'h02;
        tick();
        total++;
        if (LocalRAM_DOUT !== 8'h00) begin
            bad++; $display("FAIL btn_release: got %02h expected 00", LocalRAM_DOUT);
        end
        RAM_Addr = 8'h03;
        tick();
        total++;
        if (LocalRAM_DOUT !== {4'h0, m_evt}) begin
            bad++; $display("FAIL evt_sticky: got %02h expected %02h", LocalRAM_DOUT, {4'h0, m_evt});
        end
    endtask

    task automatic test_irq();
        logic exp_irq;
        do_write(8'h04, 8'h01);
        exp_irq = |(m_evt & m_en);
        total++;
        if (irq !== exp_irq || exp_irq !== 1'b1) begin
            bad++; $display("FAIL irq_enable: got %b expected 1", irq);
        end
        do_write(8'h03, 8'h01);
        exp_irq = |(m_evt & m_en);
        total++;
        if (irq !== exp_irq) begin
            bad++; $display("FAIL irq_w1c: got %b expected %b", irq, exp_irq);
        end
        // Press lands on the same edge as the W1C commit: set must win
        btn_in = 4'b0001;
        repeat (5) tick();
        RAM_Addr      = 8'h04;
        RemoteRAM_DIN = 8'h01;
        RemoteRAM_W   = 1'b1;
        tick();
        RemoteRAM_W = 1'b0;
        tick();
        model_write(8'h03, 8'h01);
        m_evt = m_evt | 4'b0001;
        m_btn = 4'b0001;
        exp_irq = |(m_evt & m_en);
        total++;
        if (irq !== exp_irq) begin
            bad++; $display("FAIL irq_set_wins: got %b expected %b", irq, exp_irq);
        end
        RAM_Addr = 8'h03;
        tick();
        total++;
        if (LocalRAM_DOUT !== {4'h0, m_evt}) begin
            bad++; $display("FAIL evt_set_wins: got %02h expected %02h", LocalRAM_DOUT, {4'h0, m_evt});
        end
        btn_in = 4'b0000;
        repeat (8) tick();
        m_btn = 4'b0000;
    endtask

    task automatic test_ro_unmapped();
        logic [7:0] addrs [3];
        addrs[0] = 8'h00;
        addrs[1] = 8'h01;
        addrs[2] = 8'h10;
        for (int unsigned i = 0; i < 3; i++) do_write(addrs[i], 8'hFF);
        for (int unsigned i = 0; i < 3; i++) begin
            RAM_Addr = addrs[i];
            tick();
            total++;
            if (LocalRAM_DOUT !== model_read(addrs[i])) begin
                bad++; $display("FAIL ro_read[%02h]: got %02h expected %02h", addrs[i], LocalRAM_DOUT, model_read(addrs[i]));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] addrs [6];
        do_write(8'h05, 8'h33);
        do_write(8'h22, 8'h44);
        do_write(8'h04, 8'h01);
        total++;
        if (irq !== |(m_evt & m_en)) begin
            bad++; $display("FAIL pre_reset_irq: got %b expected %b", irq, |(m_evt & m_en));
        end
        lcd_rd_addr   = 5'd2;
        RAM_Addr      = 8'h06;
        RemoteRAM_DIN = 8'h77;
        RemoteRAM_W   = 1'b1;
        reset         = 1'b0;
        tick();
        total++;
        if (LocalRAM_DOUT !== 8'h00 || irq !== 1'b0 || lcd_rd_data !== 8'h00) begin
            bad++; $display("FAIL mid_reset_outputs: got dout=%02h irq=%b lcd=%02h expected 00/0/00",
                            LocalRAM_DOUT, irq, lcd_rd_data);
        end
        tick();
        reset = 1'b1;
        model_reset();
        repeat (8) tick();
        addrs[0] = 8'h01; addrs[1] = 8'h02; addrs[2] = 8'h03;
        addrs[3] = 8'h04; addrs[4] = 8'h05; addrs[5] = 8'h22;
        for (int unsigned i = 0; i < 6; i++) begin
            RAM_Addr = addrs[i];
            tick();
            total++;
            if (LocalRAM_DOUT !== model_read(addrs[i])) begin
                bad++; $display("FAIL post_reset[%02h]: got %02h expected %02h", addrs[i], LocalRAM_DOUT, model_read(addrs[i]));
            end
        end
        total++;
        if (lcd_rd_data !== 8'h20) begin
            bad++; $display("FAIL post_reset_lcd: got %02h expected 20", lcd_rd_data);
        end
        RAM_Addr = 8'h06;
        tick();
        RemoteRAM_W = 1'b0;
        tick();
        RemoteRAM_W = 1'b1;
        tick();
        RemoteRAM_W = 1'b0;
        model_write(8'h05, 8'h77);
        RAM_Addr = 8'h05;
        tick();
        total++;
        if (LocalRAM_DOUT !== 8'h77) begin
            bad++; $display("FAIL toggle_after_reset: got %02h expected 77", LocalRAM_DOUT);
        end
    endtask

    initial begin
        test_reset();
        test_write_once();
        test_lcd();
        test_random_regs();
        test_switches();
        test_debounce();
        test_irq();
        test_ro_unmapped();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
